rsa_modexp: RTL and testbench

- Parametrised modular-exponentiation engine; successor to the fixed 32-bit RSA core.
- Computes r = m^e mod n using right-to-left binary square-and-multiply over a bit-serial interleaved modular multiplier.
- Adds a start/busy/done handshake, operand validation with an error flag, early termination, and reset.
- Sits between the operand memory/stimulus logic and the result display path.

---
 rtl/rsa_pkg.sv | 24 ++
 rtl/rsa_modexp_if.sv | 19 +
 rtl/rsa_mod_mult.sv | 102 ++++++++++
 rtl/rsa_modexp.sv | 170 +++++++++++++++++
 tb/tb_rsa_modexp.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the rsa_modexp engine: FSM state encoding, default
// operand width and the fixed latency of the constant-time build
// (RSA_CONST_TIME_EN).
package rsa_pkg;

   localparam int RSA_WIDTH_DEFAULT = 32;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CHECK    = 3'd1,
      MUL      = 3'd2,
      MUL_WAIT = 3'd3,
      SQR      = 3'd4,
      SQR_WAIT = 3'd5,
      DONE     = 3'd6
   } rsa_state_e;

   // Cycles from the go cycle to d in the constant-time build: go/CHECK plus
   // one multiply and one square of (w+2) cycles for every exponent bit.
   function automatic int const_time_latency(input int w);
      return 2 + 2 * w * (w + 2);
   endfunction

endpackage

// File: rtl/rsa_modexp_if.sv
// Start/result handshake bundle of rsa_modexp. The slave side is the engine,
// the master side is the operand source / result consumer.
interface rsa_modexp_if
   import rsa_pkg::*;
#(
   parameter int WIDTH = RSA_WIDTH_DEFAULT
);
   logic             go;
   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] e;
   logic [WIDTH-1:0] n;
   logic [WIDTH-1:0] r;
   logic             d;
   logic             busy;
   logic             err;

   modport master (output go, m, e, n, input r, d, busy, err);
   modport slave  (input go, m, e, n, output r, d, busy, err);
endinterface

// File: rtl/rsa_mod_mult.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n, with a, b < n.
// One start cycle, WIDTH iteration cycles (b consumed MSB first), then mdone
// pulses for one cycle with the product on p.
module rsa_mod_mult
   import rsa_pkg::*;
#(
   parameter int WIDTH = RSA_WIDTH_DEFAULT
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] n,
   output logic [WIDTH-1:0] p,
   output logic             mdone
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_IT = CW'(WIDTH - 1);

   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d, p_q, p_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             run_q, run_d, done_q, done_d;
   logic [WIDTH:0]   t_dbl_s, t_red_s, t_add_s;

   // Operand, partial-product and iteration-counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q    <= {WIDTH{1'b0}};
         b_q    <= {WIDTH{1'b0}};
         n_q    <= {WIDTH{1'b0}};
         p_q    <= {WIDTH{1'b0}};
         cnt_q  <= {CW{1'b0}};
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         n_q    <= n_d;
         p_q    <= p_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         done_q <= done_d;
      end
   end

   // One interleaved step: p <- (2p + b_msb*a) mod n, WIDTH+1 bits wide so
   // neither the doubling nor the addition can overflow.
   always_comb begin
      t_dbl_s = {p_q, 1'b0};
      if (t_dbl_s >= {1'b0, n_q}) begin
         t_red_s = t_dbl_s - {1'b0, n_q};
      end else begin
         t_red_s = t_dbl_s;
      end
      if (b_q[WIDTH-1]) begin
         t_add_s = t_red_s + {1'b0, a_q};
      end else begin
         t_add_s = t_red_s;
      end
   end

   // Load on start, iterate while running, flag completion after the last step.
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      n_d    = n_q;
      p_d    = p_q;
      cnt_d  = cnt_q;
      run_d  = run_q;
      done_d = 1'b0;
      if (start) begin
         a_d   = a;
         b_d   = b;
         n_d   = n;
         p_d   = {WIDTH{1'b0}};
         cnt_d = {CW{1'b0}};
         run_d = 1'b1;
      end else if (run_q) begin
         if (t_add_s >= {1'b0, n_q}) begin
            p_d = WIDTH'(t_add_s - {1'b0, n_q});
         end else begin
            p_d = t_add_s[WIDTH-1:0];
         end
         b_d   = b_q << 1;
         cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
         if (cnt_q == LAST_IT) begin
            run_d  = 1'b0;
            done_d = 1'b1;
         end else begin
            run_d  = 1'b1;
         end
      end else begin
         run_d = 1'b0;
      end
   end

   assign p     = p_q;
   assign mdone = done_q;

endmodule

// File: rtl/rsa_modexp.sv
// Modular exponentiation r = m^e mod n, right-to-left square-and-multiply on
// top of rsa_mod_mult. Optional build macro RSA_CONST_TIME_EN: every exponent
// bit costs one multiply and one square regardless of its value, so the
// latency of valid operands is fixed.
module rsa_modexp
   import rsa_pkg::*;
#(
   parameter int WIDTH = RSA_WIDTH_DEFAULT
)
(
   input  logic        clk,
   input  logic        reset,
   rsa_modexp_if.slave bus
);
`ifdef RSA_CONST_TIME_EN
   localparam bit CONST_TIME = 1'b1;
`else
   localparam bit CONST_TIME = 1'b0;
`endif
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0]    LAST_IDX = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   rsa_state_e       state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d, base_q, base_d, exp_q, exp_d, n_q, n_d, r_q, r_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             d_q, d_d, busy_q, busy_d, err_q, err_d;
   logic             mult_start_s, mult_done_s, last_bit_s;
   logic [WIDTH-1:0] mult_a_s, mult_p_s;

   rsa_mod_mult #(.WIDTH(WIDTH)) u_mult (
      .clk   (clk),
      .reset (reset),
      .start (mult_start_s),
      .a     (mult_a_s),
      .b     (base_q),
      .n     (n_q),
      .p     (mult_p_s),
      .mdone (mult_done_s)
   );

   // FSM state, datapath registers and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= ZERO;
         base_q  <= ZERO;
         exp_q   <= ZERO;
         n_q     <= ZERO;
         r_q     <= ZERO;
         cnt_q   <= {CW{1'b0}};
         d_q     <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         base_q  <= base_d;
         exp_q   <= exp_d;
         n_q     <= n_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   // Stop after this bit's square when it is the top index or, in the
   // data-dependent build, when no exponent bits remain from this index up.
   always_comb begin
      last_bit_s = (cnt_q == LAST_IDX) || (!CONST_TIME && (exp_q == ZERO));
   end

   // Next-state and datapath control; exp_q always holds e >> i.
   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      base_d       = base_q;
      exp_d        = exp_q;
      n_d          = n_q;
      r_d          = r_q;
      cnt_d        = cnt_q;
      d_d          = d_q;
      busy_d       = busy_q;
      err_d        = err_q;
      mult_start_s = 1'b0;
      mult_a_s     = acc_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.go) begin
               state_d = CHECK;
               base_d  = bus.m;
               exp_d   = bus.e;
               n_d     = bus.n;
               busy_d  = 1'b1;
               d_d     = 1'b0;
               r_d     = ZERO;
               err_d   = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         CHECK: begin
            if ((n_q == ZERO) || (base_q >= n_q)) begin
               state_d = DONE;
               err_d   = 1'b1;
               r_d     = ZERO;
               d_d     = 1'b1;
               busy_d  = 1'b0;
            end else if (n_q == ONE) begin
               state_d = DONE;
               err_d   = 1'b0;
               r_d     = ZERO;
               d_d     = 1'b1;
               busy_d  = 1'b0;
            end else begin
               acc_d   = ONE;
               cnt_d   = {CW{1'b0}};
               state_d = (CONST_TIME || exp_q[0]) ? MUL : SQR;
            end
         end
         MUL: begin
            mult_start_s = 1'b1;
            mult_a_s     = acc_q;
            state_d      = MUL_WAIT;
         end
         MUL_WAIT: begin
            if (mult_done_s) begin
               acc_d   = exp_q[0] ? mult_p_s : acc_q;
               state_d = SQR;
            end else begin
               state_d = MUL_WAIT;
            end
         end
         SQR: begin
            mult_start_s = 1'b1;
            mult_a_s     = base_q;
            state_d      = SQR_WAIT;
         end
         SQR_WAIT: begin
            if (mult_done_s) begin
               base_d = mult_p_s;
               if (last_bit_s) begin
                  state_d = DONE;
                  r_d     = acc_q;
                  d_d     = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  exp_d   = exp_q >> 1;
                  cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                  state_d = (CONST_TIME || exp_q[1]) ? MUL : SQR;
               end
            end else begin
               state_d = SQR_WAIT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.r    = r_q;
   assign bus.d    = d_q;
   assign bus.busy = busy_q;
   assign bus.err  = err_q;

endmodule

// File: tb/tb_rsa_modexp.sv
// Directed and randomised bench for rsa_modexp (32-bit and 8-bit instances).
// Expected results are queued when an operation is issued and popped when d
// rises.
module tb_rsa_modexp;
   import rsa_pkg::*;

   typedef struct packed {
      logic [31:0] r;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   t_go = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   rsa_modexp_if #(.WIDTH(32)) bus32 ();
   rsa_modexp_if #(.WIDTH(8))  bus8 ();

   rsa_modexp #(.WIDTH(32)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32));
   rsa_modexp #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .bus(bus8));

   function automatic logic [31:0] ref_modexp(input logic [31:0] m, input logic [31:0] e,
                                              input logic [31:0] n);
      longint unsigned acc, mm, nn;
      nn  = {32'd0, n};
      mm  = {32'd0, m};
      acc = 64'd1 % nn;
      for (int i = 31; i >= 0; i--) begin
         acc = (acc * acc) % nn;
         if (e[i]) acc = (acc * mm) % nn;
      end
      return acc[31:0];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic start_op(input bit w8, input logic [31:0] m, input logic [31:0] e,
                           input logic [31:0] n, input logic [31:0] r_exp, input bit err_exp);
      exp_t ex;
      @(negedge clk);
      if (w8) begin
         bus8.m  = m[7:0];
         bus8.e  = e[7:0];
         bus8.n  = n[7:0];
         bus8.go = 1'b1;
      end else begin
         bus32.m  = m;
         bus32.e  = e;
         bus32.n  = n;
         bus32.go = 1'b1;
      end
      ex.r   = r_exp;
      ex.err = err_exp;
      sb_q.push_back(ex);
      @(posedge clk);
      #1;
      t_go     = cyc;
      bus8.go  = 1'b0;
      bus32.go = 1'b0;
      check("busy_after_go", w8 ? bus8.busy : bus32.busy, 1);
   endtask

   task automatic wait_done(input bit w8, input int max, input string tag, output int lat);
      exp_t ex;
      lat = -1;
      for (int i = 0; i < max; i++) begin
         @(posedge clk);
         #1;
         if (w8 ? bus8.d : bus32.d) begin
            lat = cyc - t_go + 1;
            break;
         end
      end
      check({tag, "_finished"}, lat >= 0, 1);
      if (lat >= 0) begin
         check({tag, "_sb_has_entry"}, sb_q.size() > 0, 1);
         if (sb_q.size() > 0) begin
            ex = sb_q.pop_front();
            check({tag, "_r"},   w8 ? {24'd0, bus8.r} : bus32.r, ex.r);
            check({tag, "_err"}, w8 ? bus8.err : bus32.err, ex.err);
            check({tag, "_busy_low"}, w8 ? bus8.busy : bus32.busy, 0);
         end
      end
   endtask

   initial begin
      int          lat;
      logic [31:0] rm, re, rn;
      int          lat_e1;

`ifdef RSA_CONST_TIME_EN
      lat_e1 = 2178;
`else
      lat_e1 = 104;
`endif
      reset    = 1'b1;
      bus32.go = 1'b0;
      bus32.m  = 32'd0;
      bus32.e  = 32'd0;
      bus32.n  = 32'd0;
      bus8.go  = 1'b0;
      bus8.m   = 8'd0;
      bus8.e   = 8'd0;
      bus8.n   = 8'd0;
      repeat (3) @(negedge clk);
      check("rst_d", bus32.d, 0);
      check("rst_busy", bus32.busy, 0);
      check("rst_err", bus32.err, 0);
      check("rst_r", bus32.r, 0);
      check("rst8_d", bus8.d, 0);
      reset = 1'b0;

      // Main function.
      start_op(1'b0, 32'd190, 32'd3, 32'd1189, 32'd848, 1'b0);
      wait_done(1'b0, 3000, "m190_e3", lat);
      check("d_held", bus32.d, 1);
      start_op(1'b0, 32'd4, 32'd13, 32'd497, 32'd445, 1'b0);
      wait_done(1'b0, 3000, "m4_e13", lat);
      start_op(1'b0, 32'd5, 32'd0, 32'd1189, 32'd1, 1'b0);
      wait_done(1'b0, 3000, "e0", lat);
      start_op(1'b0, 32'd0, 32'd7, 32'd1189, 32'd0, 1'b0);
      wait_done(1'b0, 3000, "m0", lat);

      // Operand errors and the trivial modulus.
      start_op(1'b0, 32'd5, 32'd3, 32'd0, 32'd0, 1'b1);
      wait_done(1'b0, 3000, "n0", lat);
      check("n0_latency", lat, 2);
      start_op(1'b0, 32'd1200, 32'd3, 32'd1189, 32'd0, 1'b1);
      wait_done(1'b0, 3000, "m_ge_n", lat);
      start_op(1'b0, 32'd0, 32'd5, 32'd1, 32'd0, 1'b0);
      wait_done(1'b0, 3000, "n1", lat);

      // Latency.
      start_op(1'b0, 32'd2, 32'd1, 32'd1189, 32'd2, 1'b0);
      wait_done(1'b0, 3000, "lat_e1", lat);
      check("lat_e1_cycles", lat, lat_e1);
      start_op(1'b0, 32'd2, 32'hFFFF_FFFF, 32'd1189,
               ref_modexp(32'd2, 32'hFFFF_FFFF, 32'd1189), 1'b0);
      wait_done(1'b0, 3000, "lat_eall", lat);
      check("lat_eall_cycles", lat, 2178);

      // go while busy is ignored.
      start_op(1'b0, 32'd190, 32'd3, 32'd1189, 32'd848, 1'b0);
      repeat (20) @(posedge clk);
      @(negedge clk);
      bus32.m  = 32'd4;
      bus32.e  = 32'd13;
      bus32.n  = 32'd497;
      bus32.go = 1'b1;
      @(negedge clk);
      bus32.go = 1'b0;
      wait_done(1'b0, 3000, "go_ignored", lat);

      // Reset during the first multiply aborts the operation.
      start_op(1'b0, 32'd190, 32'd3, 32'd1189, 32'd848, 1'b0);
      repeat (10) @(posedge clk);
      #2;
      check("busy_before_abort", bus32.busy, 1);
      reset = 1'b1;
      #1;
      check("abort_d", bus32.d, 0);
      check("abort_busy", bus32.busy, 0);
      check("abort_err", bus32.err, 0);
      check("abort_r", bus32.r, 0);
      void'(sb_q.pop_back());
      @(negedge clk);
      reset = 1'b0;
      start_op(1'b0, 32'd190, 32'd3, 32'd1189, 32'd848, 1'b0);
      wait_done(1'b0, 3000, "after_abort", lat);

      // Randomised 8-bit vectors against the reference model.
      for (int k = 0; k < 300; k++) begin
         rn = 32'($urandom_range(255, 2));
         rm = 32'($urandom_range(int'(rn) - 1, 0));
         re = 32'($urandom_range(255, 0));
         start_op(1'b1, rm, re, rn, ref_modexp(rm, re, rn), 1'b0);
         wait_done(1'b1, 400, "rand8", lat);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
